// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths and FSM encoding for the MEM-stage data-cache access controller.
package mem_access_ctrl_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/mem_access_ctrl_sat_counter16.sv
// 16-bit saturating event counter, cleared asynchronously by an active-high reset.
module sat_counter16 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [15:0] o_count
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + 16'd1;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: issues loads/stores, stalls the pipeline on misses.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_ready,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic [15:0]       miss_cnt,
  output logic              err
);
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              w_access;
  logic              w_illegal;
  logic              w_miss;
  logic              w_rd_done;

  assign w_access  = valid_in & (mem_read_in ^ mem_write_in);
  assign w_illegal = valid_in & mem_read_in & mem_write_in;

  // rst_n is active-high; the combinational cache-side outputs are forced quiet while it is held.
  always_comb begin
    w_next    = r_state;
    dc_req    = '0;
    dc_we     = '0;
    dc_addr   = r_addr;
    dc_wdata  = r_wdata;
    stall_out = '0;
    w_miss    = '0;
    w_rd_done = '0;
    if (!rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            dc_req    = '1;
            dc_we     = mem_write_in;
            dc_addr   = addr_in;
            dc_wdata  = wdata_in;
            stall_out = ~dc_ready;
            w_miss    = ~dc_ready;
            w_rd_done = dc_ready & mem_read_in;
            if (!dc_ready) w_next = WAIT;
          end
        end
        WAIT: begin
          dc_req    = '1;
          dc_we     = r_we;
          stall_out = ~dc_ready;
          w_rd_done = dc_ready & ~r_we;
          if (dc_ready) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= '0;
      rdata_out   <= '0;
      rdata_valid <= '0;
      err         <= '0;
    end else begin
      r_state     <= w_next;
      rdata_valid <= w_rd_done;
      if (w_miss) begin
        r_addr  <= addr_in;
        r_wdata <= wdata_in;
        r_we    <= mem_write_in;
      end
      if (w_rd_done) rdata_out <= dc_rdata;
      if ((r_state == IDLE) && w_illegal) err <= '1;
    end
  end

  sat_counter16 u_miss_cnt (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_inc   (w_miss),
    .o_count (miss_cnt)
  );
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against an outstanding-access model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0;
  logic        dc_req, dc_we;
  logic [15:0] dc_addr, dc_wdata;
  logic        dc_ready = 1'b0;
  logic [15:0] dc_rdata = '0;
  logic        stall_out;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic [15:0] miss_cnt;
  logic        err;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata), .stall_out(stall_out),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .miss_cnt(miss_cnt), .err(err)
  );

  // Standalone counter instance on a fast clock so 65537 increments stay cheap.
  logic        clk_f = 1'b0, rst_f = 1'b1, inc_f = 1'b0;
  logic [15:0] cnt_f;
  logic [15:0] sat_snap = '0;
  logic        sat_done = 1'b0;
  always #1 clk_f = ~clk_f;

  sat_counter16 u_sat (.i_clk(clk_f), .i_rst(rst_f), .i_inc(inc_f), .o_count(cnt_f));

  initial begin
    repeat (2) @(posedge clk_f);
    @(negedge clk_f);
    rst_f = 1'b0;
    inc_f = 1'b1;
    repeat (65534) @(negedge clk_f);
    sat_snap = cnt_f;
    repeat (8) @(negedge clk_f);
    inc_f = 1'b0;
    sat_done = 1'b1;
  end

  // Model: one outstanding access record plus the architecturally visible registers.
  bit          m_pend = 1'b0, m_we = 1'b0, m_rvalid = 1'b0, m_err = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  int unsigned m_miss = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      m_pend <= 1'b0; m_we <= 1'b0; m_rvalid <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_miss <= 0;
    end else begin
      m_rvalid <= 1'b0;
      if (m_pend) begin
        if (dc_ready) begin
          m_pend <= 1'b0;
          if (!m_we) begin m_rdata <= dc_rdata; m_rvalid <= 1'b1; end
        end
      end else if (valid_in && mem_read_in && mem_write_in) begin
        m_err <= 1'b1;
      end else if (valid_in && (mem_read_in != mem_write_in)) begin
        if (dc_ready) begin
          if (mem_read_in) begin m_rdata <= dc_rdata; m_rvalid <= 1'b1; end
        end else begin
          m_pend <= 1'b1; m_addr <= addr_in; m_wdata <= wdata_in; m_we <= mem_write_in;
          m_miss <= (m_miss >= 65535) ? 65535 : m_miss + 1;
        end
      end
    end
  end

  typedef struct { string name; int sel; logic [15:0] exp; } lit_t;
  lit_t lits[$];

  task automatic expect_lit(input string n, input int s, input logic [15:0] e);
    lit_t t;
    t.name = n; t.sel = s; t.exp = e;
    lits.push_back(t);
  endtask

  function automatic logic [15:0] pick(input int s);
    case (s)
      0:  return rdata_out;
      1:  return {15'b0, rdata_valid};
      2:  return miss_cnt;
      3:  return {15'b0, err};
      4:  return dc_addr;
      5:  return {15'b0, stall_out};
      6:  return {15'b0, dc_we};
      7:  return dc_wdata;
      8:  return {15'b0, dc_req};
      9:  return sat_snap;
      10: return cnt_f;
      default: return {15'b0, sat_done};
    endcase
  endfunction

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic e_req, e_we, e_stall;
    lit_t l;
    if (rst_n) begin
      e_req = 1'b0; e_we = 1'b0; e_stall = 1'b0;
      chk("rdata_out", rdata_out, 16'h0000);
      chk("rdata_valid", {15'b0, rdata_valid}, 16'h0);
      chk("miss_cnt", miss_cnt, 16'h0000);
      chk("err", {15'b0, err}, 16'h0);
    end else begin
      e_req   = m_pend || (valid_in && (mem_read_in != mem_write_in));
      e_we    = e_req && (m_pend ? m_we : mem_write_in);
      e_stall = e_req && !dc_ready;
      chk("rdata_out", rdata_out, m_rdata);
      chk("rdata_valid", {15'b0, rdata_valid}, {15'b0, m_rvalid});
      chk("miss_cnt", miss_cnt, m_miss[15:0]);
      chk("err", {15'b0, err}, {15'b0, m_err});
      if (e_req) chk("dc_addr", dc_addr, m_pend ? m_addr : addr_in);
      if (e_we)  chk("dc_wdata", dc_wdata, m_pend ? m_wdata : wdata_in);
    end
    chk("dc_req", {15'b0, dc_req}, {15'b0, e_req});
    chk("dc_we", {15'b0, dc_we}, {15'b0, e_we});
    chk("stall_out", {15'b0, stall_out}, {15'b0, e_stall});
    while (lits.size() > 0) begin
      l = lits.pop_front();
      chk(l.name, pick(l.sel), l.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] w, input bit rdy, input logic [15:0] rdat);
    valid_in = v; mem_read_in = rd; mem_write_in = wr;
    addr_in = a; wdata_in = w; dc_ready = rdy; dc_rdata = rdat;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("rst_miss", 2, 16'h0000); expect_lit("rst_rvalid", 1, 16'h0);
    expect_lit("rst_rdata", 0, 16'h0000); expect_lit("rst_err", 3, 16'h0);
    step();
    // load hit
    drv(1, 1, 0, 16'h0040, 16'h0, 1, 16'hBEEF);
    expect_lit("hit_stall", 5, 16'h0); expect_lit("hit_req", 8, 16'h1); expect_lit("hit_addr", 4, 16'h0040);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("hit_rdata", 0, 16'hBEEF); expect_lit("hit_rvalid", 1, 16'h1); expect_lit("hit_miss", 2, 16'h0);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("hit_rvalid_pulse", 1, 16'h0);
    step();
    // load miss, three stalled cycles, address changes ignored in WAIT
    drv(1, 1, 0, 16'h1234, 16'h0, 0, 16'h0);
    expect_lit("lmiss_stall0", 5, 16'h1); expect_lit("lmiss_addr0", 4, 16'h1234); expect_lit("lmiss_cnt0", 2, 16'h0);
    step();
    drv(0, 0, 0, 16'hFFFF, 16'h0, 0, 16'h0);
    expect_lit("lmiss_stall1", 5, 16'h1); expect_lit("lmiss_addr1", 4, 16'h1234);
    expect_lit("lmiss_req1", 8, 16'h1); expect_lit("lmiss_cnt1", 2, 16'h1);
    step();
    drv(1, 1, 0, 16'hFFFF, 16'h0, 0, 16'h0);
    expect_lit("lmiss_stall2", 5, 16'h1); expect_lit("lmiss_addr2", 4, 16'h1234);
    step();
    drv(1, 0, 1, 16'hFFFF, 16'h0, 1, 16'h5A5A);
    expect_lit("lmiss_stall3", 5, 16'h0); expect_lit("lmiss_addr3", 4, 16'h1234); expect_lit("lmiss_we3", 6, 16'h0);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("lmiss_rdata", 0, 16'h5A5A); expect_lit("lmiss_rvalid", 1, 16'h1); expect_lit("lmiss_cnt", 2, 16'h1);
    step();
    // store miss
    drv(1, 0, 1, 16'h0010, 16'h00FF, 0, 16'h0);
    expect_lit("smiss_we0", 6, 16'h1); expect_lit("smiss_wdata0", 7, 16'h00FF); expect_lit("smiss_stall0", 5, 16'h1);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("smiss_we1", 6, 16'h1); expect_lit("smiss_wdata1", 7, 16'h00FF);
    expect_lit("smiss_stall1", 5, 16'h1); expect_lit("smiss_rvalid1", 1, 16'h0);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 1, 16'h1111);
    expect_lit("smiss_stall2", 5, 16'h0); expect_lit("smiss_we2", 6, 16'h1); expect_lit("smiss_wdata2", 7, 16'h00FF);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("smiss_rvalid", 1, 16'h0); expect_lit("smiss_rdata", 0, 16'h5A5A); expect_lit("smiss_cnt", 2, 16'h2);
    step();
    // illegal request
    drv(1, 1, 1, 16'h0020, 16'h0, 1, 16'h0);
    expect_lit("ill_req", 8, 16'h0); expect_lit("ill_stall", 5, 16'h0); expect_lit("ill_err0", 3, 16'h0);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    expect_lit("ill_err1", 3, 16'h1); expect_lit("ill_req1", 8, 16'h0);
    step();
    expect_lit("ill_err_sticky", 3, 16'h1);
    step();
    // reset in the middle of a miss
    drv(1, 1, 0, 16'h2222, 16'h0, 0, 16'h0);
    step();
    drv(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    #1 rst_n = 1'b1;
    expect_lit("rstw_req", 8, 16'h0); expect_lit("rstw_stall", 5, 16'h0); expect_lit("rstw_miss", 2, 16'h0);
    expect_lit("rstw_err", 3, 16'h0); expect_lit("rstw_rdata", 0, 16'h0); expect_lit("rstw_we", 6, 16'h0);
    step();
    rst_n = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 1, 16'h0);
    expect_lit("rstw_post_req", 8, 16'h0); expect_lit("rstw_post_stall", 5, 16'h0);
    step();
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      bit rd, wr;
      rst_n = ($urandom_range(0, 199) == 0);
      k = $urandom_range(0, 19);
      rd = (k == 0) || (k < 10);
      wr = (k == 0) || ((k >= 10) && (k < 18));
      drv($urandom_range(0, 3) != 0, rd, wr, 16'($urandom), 16'($urandom),
          $urandom_range(0, 2) != 0, 16'($urandom));
      step();
    end
    rst_n = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 1, 16'h0);
    step();
    for (int i = 0; i < 20000 && !sat_done; i++) step();
    expect_lit("sat_done", 11, 16'h1);
    expect_lit("sat_fffe", 9, 16'hFFFE);
    expect_lit("sat_ffff_nowrap", 10, 16'hFFFF);
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
